// File: rtl/uart_transceiver.sv
`default_nettype none
// =============================================================================
// Module   : uart_transceiver
// Summary  : Full-duplex UART with independent TX/RX engines sharing one baud
//            divisor. Optional parity bit enabled by defining UART_PARITY_EN.
// Revision : 1.0 - initial release
// =============================================================================
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 tx_busy,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
    // The accepting IDLE cycle supplies the final stop-bit cycle, so back-to-back frames have no gap.
    localparam logic [CW-1:0] c_stop_last = CW'(CLKS_PER_BIT * STOP_BITS - 2);
    localparam logic [BW-1:0] c_data_last = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    // ------------------------------------------------------------------ TX
    tx_state_e              tx_state_q, tx_state_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]          tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_out_q, tx_out_d;
`ifdef UART_PARITY_EN
    logic                   tx_par_q, tx_par_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_bit_d   = '0;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^tx_data ^ 1'(PARITY_ODD);
`endif
                end
            end
            TX_START: begin
                if (tx_cnt_q == c_bit_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == c_bit_last) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + BW'(1);
                    if (tx_bit_q == c_data_last) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
`else
                        tx_state_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_q == c_bit_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_q == c_stop_last) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (tx_state_d)
            TX_START:  tx_out_d = 1'b0;
            TX_DATA:   tx_out_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_out_d = tx_par_d;
`endif
            default:   tx_out_d = 1'b1;
        endcase
    end

    assign tx       = tx_out_q;
    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_busy  = (tx_state_q != TX_IDLE);

    // ------------------------------------------------------------------ RX
    logic [1:0]             rx_sync_q;
    logic                   rx_prev_q;
    logic                   w_rx_s;
    rx_state_e              rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]          rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
    logic                   rx_par_q, rx_par_d;
    logic                   rx_perr_q, rx_perr_d;
`endif

    assign w_rx_s = rx_sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx};
            rx_prev_q  <= w_rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = rx_ferr_q;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !w_rx_s) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == c_half_last) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = w_rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {w_rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BW'(1);
                    if (rx_bit_q == c_data_last) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = w_rx_s;
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d   = '0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = !w_rx_s;
`ifdef UART_PARITY_EN
                    rx_perr_d  = rx_par_q != (^rx_shift_q ^ 1'(PARITY_ODD));
`endif
                    rx_state_d = w_rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (w_rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_busy      = (rx_state_q != RX_IDLE);
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
    logic unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_transceiver
// Summary  : Self-checking bench for uart_transceiver (16 clk/bit, 8N1 loopback).
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_transceiver;

    localparam int CPB     = 16;
    localparam int PAR_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int PAR_EN  = 1;
`else
    localparam int PAR_EN  = 0;
`endif
    localparam int FRAME_BITS = 1 + 8 + PAR_EN + 1;
    localparam int FRAME_CYC  = FRAME_BITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       tx_busy;
    logic       rx_busy;

    logic       loop;
    logic       rx_drv;
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         rxv_count = 0;
    int         cyc = 0;
    exp_t       sb_q[$];
    exp_t       mon_e;

    assign rx_line = loop ? tx : rx_drv;

    uart_transceiver #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PARITY_ODD   (PAR_ODD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx            (tx),
        .rx            (rx_line),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .tx_busy       (tx_busy),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && rx_valid) begin
            rxv_count++;
            if (sb_q.size() == 0) begin
                check("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
                check("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, mon_e.ferr});
                check("rx_parity_err", {31'd0, rx_parity_err}, {31'd0, mon_e.perr});
            end
        end
    end

    function automatic logic par_of(input logic [7:0] d);
        return ^d ^ 1'(PAR_ODD);
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, sb_q.size(), 0);
    endtask

    // Sends one byte and checks the line bit-by-bit, every cycle of every bit.
    task automatic send_frame_check(input logic [7:0] d);
        logic [15:0] bits;
        logic        act_v;
        int          nb;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (PAR_EN != 0) begin
            bits[nb] = par_of(d);
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        check("tx_ready_before_send", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        sb_q.push_back('{d, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        for (int b = 0; b < nb; b++) begin
            act_v = bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (tx !== bits[b]) act_v = tx;
                if (!(b == nb - 1 && c == CPB - 1)) @(negedge clk);
            end
            check($sformatf("tx_bit%0d_of_%02h", b, d), {31'd0, act_v}, {31'd0, bits[b]});
        end
        @(negedge clk);
        check("tx_ready_after_frame", {31'd0, tx_ready}, 32'd1);
        check("tx_idle_high", {31'd0, tx}, 32'd1);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic flip_par, input logic stop_v);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (PAR_EN != 0) begin
            rx_drv = par_of(d) ^ flip_par;
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_v;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   start_t[5];
        int   base;
        int   k;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 8'h55, 1'b0, 1'b0};
        vecs[3] = '{8'h81, 8'h81, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 8'h3C, 1'b0, 1'b0};

        rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loop = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("reset_parity_err", {31'd0, rx_parity_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame with full waveform check
        send_frame_check(8'hA5);
        wait_drain("rx_a5_drain", 200);

        // Back-to-back frames from the table, tx_valid held high throughout
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = vecs[i].din;
            sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr});
            k = 0;
            while (!tx_ready && k < 400) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("b2b_ready_%0d", i), {31'd0, tx_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            start_t[i] = cyc;
            check($sformatf("b2b_start_low_%0d", i), {31'd0, tx}, 32'd0);
            if (i > 0) check($sformatf("b2b_spacing_%0d", i), start_t[i] - start_t[i-1], FRAME_CYC);
        end
        tx_valid = 1'b0;
        wait_drain("rx_b2b_drain", 2 * FRAME_CYC);
        repeat (CPB) @(negedge clk);

        // Start-bit glitch on the line input
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        base = rxv_count;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        check("glitch_rx_busy_seen", {31'd0, rx_busy}, 32'd1);
        k = 0;
        while (rx_busy && k < 12) begin
            @(negedge clk);
            k++;
        end
        check("glitch_rx_busy_cleared", {31'd0, rx_busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("glitch_no_rx_valid", rxv_count, base);

        // Frame with low stop bit followed by a held-low break
        base = rxv_count;
        sb_q.push_back('{8'h3C, 1'b1, 1'b0});
        drive_rx_frame(8'h3C, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("break_one_rx_valid", rxv_count, base + 1);
        check("break_sb_empty", sb_q.size(), 0);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("break_no_extra_valid", rxv_count, base + 1);
        sb_q.push_back('{8'h5A, 1'b0, 1'b0});
        drive_rx_frame(8'h5A, 1'b0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        wait_drain("rx_after_break_drain", 100);

        // Break starting from idle: one all-zero frame with a framing error
        base = rxv_count;
        sb_q.push_back('{8'h00, 1'b1, par_of(8'h00) ^ 1'b0 ? 1'b1 : 1'b0});
        rx_drv = 1'b0;
        repeat (2 * FRAME_CYC) @(negedge clk);
        check("idle_break_one_valid", rxv_count, base + 1);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_break_after_release", rxv_count, base + 1);

`ifdef UART_PARITY_EN
        loop = 1'b1;
        repeat (4) @(negedge clk);
        send_frame_check(8'h07);
        wait_drain("rx_parity_ok_drain", 200);
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        sb_q.push_back('{8'h07, 1'b0, 1'b1});
        drive_rx_frame(8'h07, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        wait_drain("rx_parity_err_drain", 100);
`endif

        // Reset in the middle of data bit 3 of both engines
        loop = 1'b1;
        repeat (4) @(negedge clk);
        base = rxv_count;
        tx_data = 8'h96;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
        check("midframe_tx_busy_before_rst", {31'd0, tx_busy}, 32'd1);
        check("midframe_rx_busy_before_rst", {31'd0, rx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * FRAME_CYC) @(negedge clk);
        check("midrst_no_rx_valid", rxv_count, base);
        send_frame_check(8'hC3);
        wait_drain("rx_after_reset_drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
